// File: rtl/result_pkg.sv
// Shared encodings for the result tracker: FSM states, game-core result codes
// and RGB LED patterns ([2]=red, [1]=green, [0]=blue).
package result_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BLINK_OK  = 3'd1,
    ST_HOLD_OK   = 3'd2,
    ST_BLINK_ERR = 3'd3,
    ST_HOLD_ERR  = 3'd4,
    ST_WIN       = 3'd5,
    ST_OVER      = 3'd6
  } state_t;

  localparam logic [2:0] RES_IDLE = 3'b000;
  localparam logic [2:0] RES_OK   = 3'b010;
  localparam logic [2:0] RES_ERR  = 3'b001;

  localparam logic [2:0] LED_OFF   = 3'b000;
  localparam logic [2:0] LED_RED   = 3'b100;
  localparam logic [2:0] LED_GREEN = 3'b010;
  localparam logic [2:0] LED_WIN   = 3'b011;

endpackage

// File: rtl/blink_timer.sv
// Blink sequencer: 2*BLINKS half-periods of BLINK_CYCLES clocks each, restartable.
// phase_on is the LED phase for the coming cycle so the caller can register it.
module blink_timer #(
  parameter int BLINK_CYCLES = 31_250_000,
  parameter int BLINKS       = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic phase_on,
  output logic done
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int HW = (2 * BLINKS > 1) ? $clog2(2 * BLINKS) : 1;

  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] half, half_n;
  logic          active, active_n;
  logic          wrap;

  assign wrap = active && (cnt == CW'(BLINK_CYCLES - 1));
  assign done = wrap && (half == HW'(2 * BLINKS - 1));

  // A restart outranks completion so a fresh event always gets a full blink.
  always_comb begin
    cnt_n    = cnt;
    half_n   = half;
    active_n = active;
    if (start) begin
      cnt_n    = '0;
      half_n   = '0;
      active_n = 1'b1;
    end else if (done) begin
      cnt_n    = '0;
      half_n   = '0;
      active_n = 1'b0;
    end else if (wrap) begin
      cnt_n  = '0;
      half_n = half + 1'b1;
    end else if (active) begin
      cnt_n = cnt + 1'b1;
    end
  end

  assign phase_on = active_n && !half_n[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      half   <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      half   <= half_n;
      active <= active_n;
    end
  end

endmodule

// File: rtl/result_tracker.sv
// Turns game-core result codes into score/lives bookkeeping and RGB LED blink
// feedback; WIN and GAME-OVER latch until reset.
module result_tracker
  import result_pkg::*;
#(
  parameter int BLINK_CYCLES = 31_250_000,
  parameter int BLINKS       = 3,
  parameter int MAX_LIVES    = 3,
  parameter int LEVELS       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] result,
  output logic [2:0] led_rgb,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       win,
  output logic       game_over
);

  logic [2:0] res_q, res_qq;
  state_t     state, state_n;
  logic [3:0] score_n;
  logic [1:0] lives_n;
  logic       ok_evt, err_evt, accept, start;
  logic       phase_on, done;

  function automatic logic [2:0] led_for(input state_t s, input logic ph);
    case (s)
      ST_BLINK_OK:  led_for = ph ? LED_GREEN : LED_OFF;
      ST_BLINK_ERR: led_for = ph ? LED_RED : LED_OFF;
      ST_HOLD_OK:   led_for = LED_GREEN;
      ST_HOLD_ERR:  led_for = LED_RED;
      ST_WIN:       led_for = LED_WIN;
      ST_OVER:      led_for = LED_RED;
      default:      led_for = LED_OFF;
    endcase
  endfunction

  // Edge detection on the code: a held submission counts only once.
  assign ok_evt  = (res_q == RES_OK) && (res_qq != RES_OK);
  assign err_evt = (res_q == RES_ERR) && (res_qq != RES_ERR);
  assign accept  = (state != ST_WIN) && (state != ST_OVER);
  assign start   = accept && (ok_evt || err_evt);

  blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES),
    .BLINKS      (BLINKS)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .phase_on(phase_on),
    .done    (done)
  );

  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    if (accept && ok_evt) begin
      score_n = (score == 4'(LEVELS)) ? score : score + 4'd1;
      state_n = (score_n == 4'(LEVELS)) ? ST_WIN : ST_BLINK_OK;
    end else if (accept && err_evt) begin
      lives_n = (lives == 2'd0) ? lives : lives - 2'd1;
      state_n = (lives_n == 2'd0) ? ST_OVER : ST_BLINK_ERR;
    end else begin
      case (state)
        ST_BLINK_OK:  if (done) state_n = (res_q == RES_OK) ? ST_HOLD_OK : ST_IDLE;
        ST_BLINK_ERR: if (done) state_n = (res_q == RES_ERR) ? ST_HOLD_ERR : ST_IDLE;
        ST_HOLD_OK:   if (res_q != RES_OK) state_n = ST_IDLE;
        ST_HOLD_ERR:  if (res_q != RES_ERR) state_n = ST_IDLE;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q     <= RES_IDLE;
      res_qq    <= RES_IDLE;
      state     <= ST_IDLE;
      score     <= 4'd0;
      lives     <= 2'(MAX_LIVES);
      led_rgb   <= LED_OFF;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      res_q     <= result;
      res_qq    <= res_q;
      state     <= state_n;
      score     <= score_n;
      lives     <= lives_n;
      led_rgb   <= led_for(state_n, phase_on);
      win       <= (state_n == ST_WIN);
      game_over <= (state_n == ST_OVER);
    end
  end

endmodule

// File: tb/tb_result_tracker.sv
// Directed bench for result_tracker with short blink timing (4-cycle half-periods).
module tb_result_tracker;

  logic       clk;
  logic       reset;
  logic [2:0] result;
  logic [2:0] led_rgb;
  logic [3:0] score;
  logic [1:0] lives;
  logic       win;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  result_tracker #(
    .BLINK_CYCLES(4),
    .BLINKS      (3),
    .MAX_LIVES   (3),
    .LEVELS      (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .result   (result),
    .led_rgb  (led_rgb),
    .score    (score),
    .lives    (lives),
    .win      (win),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    result = 3'b000;
    wait_n(2);
    reset = 1'b1;
    wait_n(1);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    result = 3'b000;
    wait_n(3);
    checks++;
    if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives_in_reset got %0d exp 3", lives); end
    reset = 1'b1;
    wait_n(20);
    checks++;
    if (led_rgb !== 3'b000) begin errors++; $display("FAIL reset_led got %b exp 000", led_rgb); end
    checks++;
    if (score !== 4'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
    checks++;
    if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", lives); end
    checks++;
    if (win !== 1'b0 || game_over !== 1'b0) begin
      errors++; $display("FAIL reset_flags got win=%b over=%b exp 0 0", win, game_over);
    end
  endtask

  task automatic test_ok_blink();
    logic [2:0] exp_led;
    do_reset();
    result = 3'b010;
    wait_n(1);
    checks++;
    if (led_rgb !== 3'b000 || score !== 4'd0) begin
      errors++; $display("FAIL ok_latency got led=%b score=%0d exp 000 0", led_rgb, score);
    end
    wait_n(1);
    checks++;
    if (score !== 4'd1) begin errors++; $display("FAIL ok_score got %0d exp 1", score); end
    for (int i = 0; i < 24; i++) begin
      exp_led = (((i / 4) % 2) == 0) ? 3'b010 : 3'b000;
      checks++;
      if (led_rgb !== exp_led) begin
        errors++; $display("FAIL ok_blink cycle %0d got %b exp %b", i, led_rgb, exp_led);
      end
      wait_n(1);
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (led_rgb !== 3'b010) begin
        errors++; $display("FAIL ok_hold cycle %0d got %b exp 010", i, led_rgb);
      end
      wait_n(1);
    end
    result = 3'b000;
    wait_n(1);
    checks++;
    if (led_rgb !== 3'b010) begin errors++; $display("FAIL ok_release_early got %b exp 010", led_rgb); end
    wait_n(1);
    checks++;
    if (led_rgb !== 3'b000) begin errors++; $display("FAIL ok_release got %b exp 000", led_rgb); end
    checks++;
    if (score !== 4'd1) begin errors++; $display("FAIL ok_score_final got %0d exp 1", score); end
  endtask

  task automatic test_preempt();
    logic [2:0] exp_led;
    do_reset();
    result = 3'b010;
    wait_n(2);
    result = 3'b001;
    wait_n(2);
    checks++;
    if (score !== 4'd1 || lives !== 2'd2) begin
      errors++; $display("FAIL preempt_counts got score=%0d lives=%0d exp 1 2", score, lives);
    end
    for (int i = 0; i < 8; i++) begin
      exp_led = (i < 4) ? 3'b100 : 3'b000;
      checks++;
      if (led_rgb !== exp_led) begin
        errors++; $display("FAIL preempt_red cycle %0d got %b exp %b", i, led_rgb, exp_led);
      end
      wait_n(1);
    end
    for (int i = 0; i < 30; i++) begin
      result = 3'b001;
      wait_n(1);
    end
    checks++;
    if (lives !== 2'd2) begin errors++; $display("FAIL repeat_no_decrement got %0d exp 2", lives); end
    checks++;
    if (led_rgb !== 3'b100) begin errors++; $display("FAIL repeat_hold_red got %b exp 100", led_rgb); end
  endtask

  task automatic test_game_over();
    logic [1:0] exp_lives;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      result = 3'b001;
      wait_n(2);
      exp_lives = 2'(2 - i);
      checks++;
      if (lives !== exp_lives) begin
        errors++; $display("FAIL over_lives step %0d got %0d exp %0d", i, lives, exp_lives);
      end
      result = 3'b000;
      wait_n(3);
    end
    checks++;
    if (game_over !== 1'b1 || led_rgb !== 3'b100) begin
      errors++; $display("FAIL over_state got over=%b led=%b exp 1 100", game_over, led_rgb);
    end
    result = 3'b010;
    wait_n(4);
    checks++;
    if (score !== 4'd0 || led_rgb !== 3'b100 || win !== 1'b0 || lives !== 2'd0) begin
      errors++;
      $display("FAIL over_ignores got score=%0d led=%b win=%b lives=%0d exp 0 100 0 0",
               score, led_rgb, win, lives);
    end
  endtask

  task automatic test_win();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      result = 3'b010;
      wait_n(2);
      checks++;
      if (score !== 4'(i + 1)) begin
        errors++; $display("FAIL win_score step %0d got %0d exp %0d", i, score, i + 1);
      end
      result = 3'b000;
      wait_n(3);
    end
    checks++;
    if (win !== 1'b1 || led_rgb !== 3'b011 || game_over !== 1'b0) begin
      errors++; $display("FAIL win_state got win=%b led=%b over=%b exp 1 011 0", win, led_rgb, game_over);
    end
    result = 3'b010;
    wait_n(4);
    checks++;
    if (score !== 4'd10 || win !== 1'b1 || led_rgb !== 3'b011) begin
      errors++; $display("FAIL win_saturate got score=%0d win=%b led=%b exp 10 1 011", score, win, led_rgb);
    end
    result = 3'b001;
    wait_n(4);
    checks++;
    if (lives !== 2'd3 || led_rgb !== 3'b011) begin
      errors++; $display("FAIL win_ignores_err got lives=%0d led=%b exp 3 011", lives, led_rgb);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      result = 3'b010;
      wait_n(2);
      result = 3'b000;
      wait_n(3);
    end
    result = 3'b010;
    wait_n(2);
    checks++;
    if (score !== 4'd4 || led_rgb !== 3'b010) begin
      errors++; $display("FAIL areset_pre got score=%0d led=%b exp 4 010", score, led_rgb);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (led_rgb !== 3'b000 || score !== 4'd0 || lives !== 2'd3 || win !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate got led=%b score=%0d lives=%0d win=%b over=%b exp 000 0 3 0 0",
               led_rgb, score, lives, win, game_over);
    end
    result = 3'b000;
    wait_n(1);
    reset = 1'b1;
    wait_n(5);
    checks++;
    if (led_rgb !== 3'b000 || score !== 4'd0) begin
      errors++; $display("FAIL areset_after got led=%b score=%0d exp 000 0", led_rgb, score);
    end
  endtask

  initial begin
    reset  = 1'b0;
    result = 3'b000;
    test_reset();
    test_ok_blink();
    test_preempt();
    test_game_over();
    test_win();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
